button_conditioner: RTL and testbench

- Conditions raw board push-buttons before they drive the console core's `ui_in` joystick/console-switch byte. That core is clocked by the 25.125 MHz pixel clock.
- Each channel gets:
  - a 2-flop synchronizer
  - a per-channel debounce counter
  - press/release edge pulses
  - a long-press detector, used for console RESET/SELECT hold behaviour
- Sits between the board pins and the core, in the `clk_pixel` domain.

---
 rtl/button_conditioner_pkg.sv | 20 ++
 rtl/button_conditioner_channel.sv | 108 ++++++++++
 rtl/button_conditioner.sv | 44 ++++
 tb/tb_button_conditioner.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared constants for the console button conditioner: ui_in bit positions
// and default timing for the 25.125 MHz pixel clock.
package button_conditioner_pkg;

  // Bit positions of the console core's ui_in byte
  typedef enum logic [2:0] {
    UI_RESET  = 3'd0,
    UI_FIRE   = 3'd1,
    UI_SELECT = 3'd2,
    UI_UP     = 3'd3,
    UI_DOWN   = 3'd4,
    UI_LEFT   = 3'd5,
    UI_RIGHT  = 3'd6
  } ui_bit_e;

  // ~2.6 ms debounce and ~1 s long press at 25.125 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 65536;
  localparam int DEFAULT_LONG_CYCLES     = 25125000;

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchronizer, debounce, press/release edge
// pulses and long-press detection.
module button_channel
  import button_conditioner_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int DB_W            = $clog2(DEBOUNCE_CYCLES),
  parameter int LG_W            = $clog2(LONG_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic long_pulse_o
);

  logic            s1_q, s2_q;
  logic            norm;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic [LG_W-1:0] lg_cnt_q, lg_cnt_d;
  logic            long_q, long_d;
  logic            lpulse_q, lpulse_d;

  // Synchronizer rests at the idle pin level so reset exit looks like "not pressed"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= ACTIVE_LOW;
      s2_q <= ACTIVE_LOW;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  assign norm = s2_q ^ ACTIVE_LOW;

  // Debounce: accept a new level only after it persists for the full count
  always_comb begin
    level_d   = level_q;
    db_cnt_d  = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (norm != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d   = norm;
        press_d   = norm;
        release_d = ~norm;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Long press: counting keys off the next level so a release landing on the
  // threshold cycle suppresses the flag
  always_comb begin
    lg_cnt_d = lg_cnt_q;
    long_d   = long_q;
    lpulse_d = 1'b0;
    if (!level_d) begin
      lg_cnt_d = '0;
      long_d   = 1'b0;
    end else if (level_q && !long_q) begin
      if (lg_cnt_q == LG_W'(LONG_CYCLES - 1)) begin
        long_d   = 1'b1;
        lpulse_d = 1'b1;
      end else begin
        lg_cnt_d = lg_cnt_q + 1'b1;
      end
    end
  end

  // Channel state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      lg_cnt_q  <= '0;
      long_q    <= 1'b0;
      lpulse_q  <= 1'b0;
    end else begin
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      lg_cnt_q  <= lg_cnt_d;
      long_q    <= long_d;
      lpulse_q  <= lpulse_d;
    end
  end

  assign level_o      = level_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_o       = long_q;
  assign long_pulse_o = lpulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw board push-buttons for the console core's ui_in byte in the
// pixel clock domain. rst_n is expected to be released synchronously to clk
// by the system reset block.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int               N_BTN           = 4,
  parameter logic [N_BTN-1:0] ACTIVE_LOW_MASK = 4'b0001,
  parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int               LONG_CYCLES     = DEFAULT_LONG_CYCLES,
  parameter int               DB_W            = $clog2(DEBOUNCE_CYCLES),
  parameter int               LG_W            = $clog2(LONG_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic [N_BTN-1:0] btn_long_pulse
);

  // Independent channels, one per button
  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[i]),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .DB_W            (DB_W),
      .LG_W            (LG_W)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw_i        (btn_raw[i]),
      .level_o      (btn_level[i]),
      .press_o      (btn_press[i]),
      .release_o    (btn_release[i]),
      .long_o       (btn_long[i]),
      .long_pulse_o (btn_long_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with short debounce/long timings.
module tb_button_conditioner;
  localparam int         N    = 4;
  localparam int         D    = 8;
  localparam int         LG   = 32;
  localparam logic [3:0] MASK = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn_raw = MASK;
  logic [3:0] btn_level, btn_press, btn_release, btn_long, btn_long_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN           (N),
    .ACTIVE_LOW_MASK (MASK),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (LG)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_raw        (btn_raw),
    .btn_level      (btn_level),
    .btn_press      (btn_press),
    .btn_release    (btn_release),
    .btn_long       (btn_long),
    .btn_long_pulse (btn_long_pulse)
  );

  // Reference model: history of normalized pin values per clock edge. The
  // value visible to the debouncer at an edge is the pin value two edges
  // earlier; the level flips when the last D visible values all disagree
  // with it. Long press is flagged once the level has been high for more
  // than LG consecutive edges.
  logic [3:0] hist[$];
  logic [3:0] m_level, m_press, m_release, m_long, m_lpulse;
  int         m_age[4];

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] prev;
    logic       flip, lnew;
    if (!rst_n) begin
      hist.delete();
      for (int k = 0; k < D + 2; k++) hist.push_back(4'b0000);
      m_level = '0; m_press = '0; m_release = '0; m_long = '0; m_lpulse = '0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
    end else begin
      prev = m_level;
      hist.push_back(btn_raw ^ MASK);
      if (hist.size() > D + 2) void'(hist.pop_front());
      for (int i = 0; i < N; i++) begin
        flip = 1'b1;
        for (int j = 0; j < D; j++) if (hist[j][i] == prev[i]) flip = 1'b0;
        if (flip) m_level[i] = ~prev[i];
        m_age[i] = m_level[i] ? m_age[i] + 1 : 0;
        lnew = m_level[i] && (m_age[i] >= LG + 1);
        m_lpulse[i] = lnew & ~m_long[i];
        m_long[i] = lnew;
      end
      m_press   = m_level & ~prev;
      m_release = ~m_level & prev;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    btn_raw = 4'b0001;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long, btn_long_pulse} !== 20'h0)
        $display("FAIL reset_outputs t=%0t got %h expected 00000", $time,
                 {btn_level, btn_press, btn_release, btn_long, btn_long_pulse});
      else n_pass++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long, btn_long_pulse} !== 20'h0)
        $display("FAIL idle_after_reset k=%0d got %h expected 00000", k,
                 {btn_level, btn_press, btn_release, btn_long, btn_long_pulse});
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    int first_lvl = -1, first_pr = -1, n_pr = 0, first_rel = -1, n_rel = 0;
    btn_raw[1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long, btn_long_pulse} !==
          {m_level, m_press, m_release, m_long, m_lpulse})
        $display("FAIL model_clean_press k=%0d got %h expected %h", k,
                 {btn_level, btn_press, btn_release, btn_long, btn_long_pulse},
                 {m_level, m_press, m_release, m_long, m_lpulse});
      else n_pass++;
      if (btn_level[1] && first_lvl < 0) first_lvl = k;
      if (btn_press[1]) begin n_pr++; if (first_pr < 0) first_pr = k; end
    end
    n_checks++;
    if (first_lvl != 10) $display("FAIL press_level_latency got %0d expected 10", first_lvl);
    else n_pass++;
    n_checks++;
    if (first_pr != 10 || n_pr != 1)
      $display("FAIL press_pulse got first=%0d count=%0d expected first=10 count=1", first_pr, n_pr);
    else n_pass++;
    btn_raw[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long, btn_long_pulse} !==
          {m_level, m_press, m_release, m_long, m_lpulse})
        $display("FAIL model_clean_release k=%0d got %h expected %h", k,
                 {btn_level, btn_press, btn_release, btn_long, btn_long_pulse},
                 {m_level, m_press, m_release, m_long, m_lpulse});
      else n_pass++;
      if (btn_release[1]) begin n_rel++; if (first_rel < 0) first_rel = k; end
    end
    n_checks++;
    if (first_rel != 10 || n_rel != 1 || btn_level[1] !== 1'b0)
      $display("FAIL release_pulse got first=%0d count=%0d level=%b expected first=10 count=1 level=0",
               first_rel, n_rel, btn_level[1]);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int first_lvl = -1, n_pr = 0, n_rel = 0;
    btn_raw[2] = 1'b1;
    for (int k = -5; k <= 25; k++) begin
      if (k == -1) btn_raw[2] = 1'b0;
      if (k == 0)  btn_raw[2] = 1'b1;
      if (k != 0) begin
        @(negedge clk);
        n_checks++;
        if ({btn_level, btn_press, btn_release, btn_long, btn_long_pulse} !==
            {m_level, m_press, m_release, m_long, m_lpulse})
          $display("FAIL model_bounce k=%0d got %h expected %h", k,
                   {btn_level, btn_press, btn_release, btn_long, btn_long_pulse},
                   {m_level, m_press, m_release, m_long, m_lpulse});
        else n_pass++;
        if (btn_level[2] && first_lvl < 0) first_lvl = k;
        if (btn_press[2]) n_pr++;
        if (btn_release[2]) n_rel++;
      end
    end
    n_checks++;
    if (first_lvl != 10 || n_pr != 1 || n_rel != 0)
      $display("FAIL bounce got level_at=%0d presses=%0d releases=%0d expected 10/1/0",
               first_lvl, n_pr, n_rel);
    else n_pass++;
    btn_raw[2] = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_active_low_long();
    int first_lvl = -1, first_long = -1, first_lp = -1, n_lp = 0, n_lp_rel = 0;
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long, btn_long_pulse} !==
          {m_level, m_press, m_release, m_long, m_lpulse})
        $display("FAIL model_long k=%0d got %h expected %h", k,
                 {btn_level, btn_press, btn_release, btn_long, btn_long_pulse},
                 {m_level, m_press, m_release, m_long, m_lpulse});
      else n_pass++;
      if (btn_level[0] && first_lvl < 0) first_lvl = k;
      if (btn_long[0] && first_long < 0) first_long = k;
      if (btn_long_pulse[0]) begin n_lp++; if (first_lp < 0) first_lp = k; end
    end
    n_checks++;
    if (first_lvl != 10) $display("FAIL active_low_level got %0d expected 10", first_lvl);
    else n_pass++;
    n_checks++;
    if (first_long != 42 || first_lp != 42 || n_lp != 1 || btn_long[0] !== 1'b1)
      $display("FAIL long_press got long_at=%0d pulse_at=%0d pulses=%0d held=%b expected 42/42/1/1",
               first_long, first_lp, n_lp, btn_long[0]);
    else n_pass++;
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (btn_long_pulse[0]) n_lp_rel++;
    end
    n_checks++;
    if (btn_long[0] !== 1'b0 || btn_level[0] !== 1'b0 || n_lp_rel != 0)
      $display("FAIL long_clear got long=%b level=%b pulses=%0d expected 0/0/0",
               btn_long[0], btn_level[0], n_lp_rel);
    else n_pass++;
  endtask

  task automatic test_release_at_threshold();
    int n_long = 0, first_rel = -1, n_rel = 0;
    btn_raw[1] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 32) btn_raw[1] = 1'b0;
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long, btn_long_pulse} !==
          {m_level, m_press, m_release, m_long, m_lpulse})
        $display("FAIL model_threshold k=%0d got %h expected %h", k,
                 {btn_level, btn_press, btn_release, btn_long, btn_long_pulse},
                 {m_level, m_press, m_release, m_long, m_lpulse});
      else n_pass++;
      if (btn_long[1] || btn_long_pulse[1]) n_long++;
      if (btn_release[1]) begin n_rel++; if (first_rel < 0) first_rel = k; end
    end
    n_checks++;
    if (n_long != 0 || first_rel != 42 || n_rel != 1)
      $display("FAIL release_wins got long_cycles=%0d release_at=%0d releases=%0d expected 0/42/1",
               n_long, first_rel, n_rel);
    else n_pass++;
  endtask

  task automatic test_reset_mid_debounce();
    int first_lvl3 = -1, first_lvl1 = -1, n_pr3 = 0;
    btn_raw[1] = 1'b1;
    repeat (15) @(negedge clk);
    n_checks++;
    if (btn_level[1] !== 1'b1) $display("FAIL pre_reset_level got %b expected 1", btn_level[1]);
    else n_pass++;
    btn_raw[3] = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({btn_level, btn_press, btn_release, btn_long, btn_long_pulse} !== 20'h0)
      $display("FAIL async_reset got %h expected 00000",
               {btn_level, btn_press, btn_release, btn_long, btn_long_pulse});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long, btn_long_pulse} !==
          {m_level, m_press, m_release, m_long, m_lpulse})
        $display("FAIL model_reset_exit k=%0d got %h expected %h", k,
                 {btn_level, btn_press, btn_release, btn_long, btn_long_pulse},
                 {m_level, m_press, m_release, m_long, m_lpulse});
      else n_pass++;
      if (btn_level[3] && first_lvl3 < 0) first_lvl3 = k;
      if (btn_level[1] && first_lvl1 < 0) first_lvl1 = k;
      if (btn_press[3]) n_pr3++;
    end
    n_checks++;
    if (first_lvl3 != 10 || n_pr3 != 1 || first_lvl1 != 10)
      $display("FAIL reset_exit got level3_at=%0d presses3=%0d level1_at=%0d expected 10/1/10",
               first_lvl3, n_pr3, first_lvl1);
    else n_pass++;
    btn_raw = MASK;
    repeat (60) @(negedge clk);
  endtask

  task automatic test_random();
    int remain[4];
    for (int i = 0; i < N; i++) remain[i] = $urandom_range(1, 12);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        remain[i]--;
        if (remain[i] <= 0) begin
          btn_raw[i] = ~btn_raw[i];
          remain[i] = ($urandom_range(0, 9) < 7) ? $urandom_range(1, 12) : $urandom_range(30, 60);
        end
      end
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release, btn_long, btn_long_pulse} !==
          {m_level, m_press, m_release, m_long, m_lpulse})
        $display("FAIL model_random k=%0d raw=%b got %h expected %h", k, btn_raw,
                 {btn_level, btn_press, btn_release, btn_long, btn_long_pulse},
                 {m_level, m_press, m_release, m_long, m_lpulse});
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_active_low_long();
    test_release_at_threshold();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
